conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 133 +++++++++++++
 tb/tb_conv_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Address/control sequencer for a KxK valid-mode convolution over one image plane.
// It feeds an external MAC and collects one quantized result per output position.
module conv_sequencer #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 3,
  parameter int ADDR_W   = 10,
  parameter int SAVE_LAT = 3,
  parameter int OUT_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic [7:0]        w_addr,
  input  logic [7:0]        w_rdata,
  output logic              clken,
  output logic              sload,
  output logic              save,
  output logic [7:0]        signal,
  output logic [7:0]        weight,
  input  logic [7:0]        convout,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data
);
  localparam int NOUT = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(NOUT - 1);
  localparam logic [7:0]        K_MAX    = 8'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_W-1:0] col, row;
  logic [7:0]        kx, ky;
  logic              iss_vld, iss_first, iss_last;
  logic              dat_vld, dat_last;
  // Shift registers carry any number of windows in flight, one bit per cycle.
  logic [SAVE_LAT-1:0] save_pipe;
  logic [OUT_LAT-1:0]  out_pipe;
  logic win_last, pass_last, final_out;

  assign win_last  = (kx == K_MAX) && (ky == K_MAX);
  assign pass_last = win_last && (col == COL_MAX) && (row == ROW_MAX);
  assign save      = save_pipe[SAVE_LAT-1];
  assign out_valid = out_pipe[OUT_LAT-1];
  assign final_out = out_valid && (out_addr == OUT_LAST);
  assign signal    = dat_vld ? img_rdata : 8'd0;
  assign weight    = dat_vld ? w_rdata : 8'd0;
  assign out_data  = out_valid ? convout : 8'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      clken     <= 1'b0;
      sload     <= 1'b0;
      img_addr  <= '0;
      w_addr    <= '0;
      out_addr  <= '0;
      col       <= '0;
      row       <= '0;
      kx        <= '0;
      ky        <= '0;
      iss_vld   <= 1'b0;
      iss_first <= 1'b0;
      iss_last  <= 1'b0;
      dat_vld   <= 1'b0;
      dat_last  <= 1'b0;
      save_pipe <= '0;
      out_pipe  <= '0;
    end else begin
      iss_vld   <= 1'b0;
      iss_first <= 1'b0;
      iss_last  <= 1'b0;
      dat_vld   <= iss_vld;
      dat_last  <= iss_vld & iss_last;
      sload     <= iss_vld & iss_first;
      save_pipe <= (save_pipe << 1) | SAVE_LAT'(dat_last);
      out_pipe  <= (out_pipe << 1) | OUT_LAT'(save);
      clken     <= iss_vld | (clken & ~final_out);
      done      <= 1'b0;
      if (out_valid) out_addr <= out_addr + 1'b1;
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          out_addr <= '0;
          col      <= '0;
          row      <= '0;
          kx       <= '0;
          ky       <= '0;
        end
        RUN: begin
          iss_vld   <= 1'b1;
          iss_first <= (kx == 8'd0) && (ky == 8'd0);
          iss_last  <= win_last;
          img_addr  <= ADDR_W'((32'(row) + 32'(ky)) * 32'(IMG_W) + 32'(col) + 32'(kx));
          w_addr    <= 8'(32'(ky) * 32'(K) + 32'(kx));
          if (kx == K_MAX) begin
            kx <= '0;
            if (ky == K_MAX) begin
              ky <= '0;
              if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
          if (pass_last) state <= DRAIN;
        end
        DRAIN: if (final_out) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer on a 5x5 image with a 3x3 kernel and a
// behavioural MAC/quantizer standing in for the convolve block.
module tb_conv_sequencer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, clken, sload, save, out_valid;
  logic [AW-1:0] img_addr, out_addr;
  logic [7:0]    img_rdata, w_addr, w_rdata, signal, weight, convout, out_data;

  conv_sequencer #(.IMG_W(5), .IMG_H(5), .K(3), .ADDR_W(AW), .SAVE_LAT(3), .OUT_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_rdata(img_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
    .clken(clken), .sload(sload), .save(save), .signal(signal), .weight(weight),
    .convout(convout), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data));

  always #5 clk = ~clk;

  // Memories with one cycle read latency, plus the MAC: 2-stage product pipe,
  // accumulator, capture on save, quantize to convout.
  logic [7:0] img_mem [0:31];
  logic [7:0] w_mem   [0:15];
  int         shift;
  int         m0, m1, acc, cap;
  logic       s0, s1;

  always @(posedge clk) begin
    img_rdata <= img_mem[img_addr[4:0]];
    w_rdata   <= w_mem[w_addr[3:0]];
    m0 <= int'($signed(signal)) * int'($signed(weight));
    s0 <= sload;
    m1 <= m0;
    s1 <= s0;
    if (clken) acc <= s1 ? m1 : acc + m1;
    if (save) cap <= acc;
    convout <= 8'(cap >>> shift);
  end

  int checks = 0, failures = 0;
  int cyc = 0, last_ov_cyc = -10, n_ov = 0, n_done = 0;
  logic [15:0] q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is written.
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (out_valid) begin
      n_ov++;
      last_ov_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_addr", int'(out_addr), int'(e[15:8]));
        chk("out_data", int'(out_data), int'(e[7:0]));
      end
    end
    if (done) begin
      n_done++;
      chk("done_gap_after_last_out", cyc - last_ov_cyc, 1);
      chk("busy_low_at_done", int'(busy), 0);
    end
  end

  // mode 0: image all 8, weights all 8, >>9 -> 1; mode 1: image[a]=a, centre tap 1.
  task automatic setup_pass(input int mode);
    for (int a = 0; a < 32; a++) img_mem[a] = (mode == 0) ? 8'd8 : 8'(a);
    for (int k = 0; k < 16; k++) w_mem[k] = (mode == 0) ? 8'd8 : ((k == 4) ? 8'd1 : 8'd0);
    shift = (mode == 0) ? 9 : 0;
    for (int n = 0; n < 9; n++)
      q.push_back({8'(n), (mode == 0) ? 8'd1 : 8'((n / 3 + 1) * 5 + n % 3 + 1)});
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic post_pass(input string nm, input int ov0, input int dn0);
    repeat (20) @(negedge clk);
    chk({nm, "_out_count"}, n_ov - ov0, 9);
    chk({nm, "_done_count"}, n_done - dn0, 1);
    chk({nm, "_busy_idle"}, int'(busy), 0);
    chk({nm, "_queue_left"}, q.size(), 0);
  endtask

  int img_exp[10] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 1};
  int ov0, dn0;

  initial begin
    reset = 1'b0; start = 1'b0;
    shift = 0; acc = 0; cap = 0; m0 = 0; m1 = 0; s0 = 0; s1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outputs_or", int'(|{done, clken, sload, save, signal, weight, out_valid,
                                 out_addr, out_data, img_addr, w_addr}), 0);

    // Pass 1: start in the first cycle after release; check address/sload/save timing.
    setup_pass(0);
    ov0 = n_ov; dn0 = n_done;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i < 10) begin
        chk($sformatf("img_addr_%0d", i), int'(img_addr), img_exp[i]);
        chk($sformatf("w_addr_%0d", i), int'(w_addr), i % 9);
      end
      chk($sformatf("sload_d%0d", i - 1), int'(sload), int'(i >= 1 && (i - 1) % 9 == 0));
      chk($sformatf("save_d%0d", i - 1), int'(save), int'(i - 1 >= 11 && (i - 12) % 9 == 0));
    end
    wait_done("p1");
    post_pass("p1", ov0, dn0);

    // Pass 2: centre-tap pattern, with start re-asserted while running.
    setup_pass(1);
    ov0 = n_ov; dn0 = n_done;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("p2");
    post_pass("p2", ov0, dn0);

    // Pass 3: one reset cycle during window 4 kills everything in flight.
    setup_pass(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (38) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_outputs_or", int'(|{done, clken, sload, save, signal, weight, out_valid,
                                    out_addr, out_data, img_addr, w_addr}), 0);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    ov0 = n_ov; dn0 = n_done;
    repeat (40) @(negedge clk);
    chk("midrst_no_out_valid", n_ov - ov0, 0);
    chk("midrst_no_done", n_done - dn0, 0);

    // Pass 4: a fresh start after the abort runs the full sequence from index 0.
    setup_pass(1);
    ov0 = n_ov; dn0 = n_done;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("p4");
    post_pass("p4", ov0, dn0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
